// File: rtl/perceptron_train_ctrl.sv
// Perceptron branch-predictor training controller: decides whether a resolved
// branch needs training, updates weights 8 per cycle, then writes the row back.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a resolution request, res_ready=1
// ST_DECIDE | evaluate mispredict / low-confidence, pick train or drop
// ST_UPDATE | adjust weight group g (8 weights per cycle), bias on g=7
// ST_WRITE  | hold write-back payload until wr_ready
module perceptron_train_ctrl #(
   parameter logic [8:0] THETA = 9'd40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         res_valid,
   output logic         res_ready,
   input  logic         res_taken,
   input  logic [8:0]   res_sum,
   input  logic [63:0]  res_hist,
   input  logic [191:0] res_weights,
   input  logic [1:0]   res_bias,
   input  logic [7:0]   res_index,
   output logic         wr_valid,
   input  logic         wr_ready,
   output logic [7:0]   wr_index,
   output logic [191:0] wr_weights,
   output logic [1:0]   wr_bias,
   output logic [15:0]  upd_cnt,
   output logic         busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_DECIDE, ST_UPDATE, ST_WRITE} state_t;

   state_t         state_q, state_d;
   logic [2:0]     g_q, g_d;
   logic [15:0]    cnt_q, cnt_d;
   logic           taken_q, taken_d;
   logic [8:0]     sum_q, sum_d;
   logic [63:0]    hist_q, hist_d;
   logic [191:0]   w_q, w_d;
   logic [1:0]     bias_q, bias_d;
   logic [7:0]     index_q, index_d;
   logic           res_ready_q, res_ready_d;
   logic           wr_valid_q, wr_valid_d;
   logic           busy_q, busy_d;

   logic [9:0]     sum_ext, mag;
   logic           pred, train;

   // |sum| needs 10 bits so that -256 maps to +256 rather than wrapping
   assign sum_ext = {sum_q[8], sum_q};
   assign mag     = sum_q[8] ? (~sum_ext + 10'd1) : sum_ext;
   assign pred    = ~sum_q[8];
   assign train   = (pred != taken_q) || (mag <= {1'b0, THETA});

   always_comb begin
      logic [2:0] w_cur;
      w_cur   = '0;
      state_d = state_q;
      g_d     = g_q;
      cnt_d   = cnt_q;
      taken_d = taken_q;
      sum_d   = sum_q;
      hist_d  = hist_q;
      w_d     = w_q;
      bias_d  = bias_q;
      index_d = index_q;
      case (state_q)
         ST_IDLE: begin
            if (res_valid) begin
               taken_d = res_taken;
               sum_d   = res_sum;
               hist_d  = res_hist;
               w_d     = res_weights;
               bias_d  = res_bias;
               index_d = res_index;
               state_d = ST_DECIDE;
            end
         end
         ST_DECIDE: begin
            g_d     = 3'd0;
            state_d = train ? ST_UPDATE : ST_IDLE;
         end
         ST_UPDATE: begin
            for (int i = 0; i < 64; i++) begin
               if ((i / 8) == int'(g_q)) begin
                  w_cur = w_q[3*i +: 3];
                  if (taken_q == hist_q[i]) begin
                     if (w_cur != 3'b011) w_d[3*i +: 3] = w_cur + 3'd1;
                  end else begin
                     if (w_cur != 3'b100) w_d[3*i +: 3] = w_cur - 3'd1;
                  end
               end
            end
            if (g_q == 3'd7) begin
               if (taken_q) begin
                  if (bias_q != 2'b01) bias_d = bias_q + 2'd1;
               end else begin
                  if (bias_q != 2'b10) bias_d = bias_q - 2'd1;
               end
               g_d     = 3'd0;
               state_d = ST_WRITE;
            end else begin
               g_d = g_q + 3'd1;
            end
         end
         ST_WRITE: begin
            if (wr_ready) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      res_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      wr_valid_d  = (state_d == ST_WRITE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         g_q         <= '0;
         cnt_q       <= '0;
         taken_q     <= 1'b0;
         sum_q       <= '0;
         hist_q      <= '0;
         w_q         <= '0;
         bias_q      <= '0;
         index_q     <= '0;
         res_ready_q <= 1'b1;
         wr_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         cnt_q       <= cnt_d;
         taken_q     <= taken_d;
         sum_q       <= sum_d;
         hist_q      <= hist_d;
         w_q         <= w_d;
         bias_q      <= bias_d;
         index_q     <= index_d;
         res_ready_q <= res_ready_d;
         wr_valid_q  <= wr_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign res_ready  = res_ready_q;
   assign wr_valid   = wr_valid_q;
   assign busy       = busy_q;
   assign wr_index   = index_q;
   assign wr_weights = w_q;
   assign wr_bias    = bias_q;
   assign upd_cnt    = cnt_q;

endmodule
